// File: rtl/frame_stream_decoder_pkg.sv
// rtl/frame_stream_decoder_pkg.sv - shared markers, state encoding and error bit indices for the frame stream decoder
package frame_stream_decoder_pkg;

    localparam int WORD_W  = 17;
    localparam int PIX_W   = 16;
    localparam int COORD_W = 11;
    localparam int ERR_W   = 4;

    localparam logic [WORD_W-1:0] MARKER_FRAME_START = 17'h10000;
    localparam logic [WORD_W-1:0] MARKER_ROW_START   = 17'h10001;
    localparam logic [WORD_W-1:0] MARKER_FRAME_END   = 17'h1FFFF;

    localparam int ERR_RESYNC         = 0;
    localparam int ERR_ROW_LEN        = 1;
    localparam int ERR_UNKNOWN_MARKER = 2;
    localparam int ERR_FRAME_END      = 3;

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_ROW_HDR   = 2'd1,
        ST_PIXELS    = 2'd2,
        ST_FRAME_END = 2'd3
    } decoder_state_t;

    // Bit 16 separates control markers from BGR565 pixel words.
    function automatic logic is_marker(input logic [WORD_W-1:0] word);
        return word[WORD_W-1];
    endfunction

endpackage

// File: rtl/frame_stream_decoder_skid.sv
// rtl/frame_stream_decoder_skid.sv - two-entry word FIFO absorbing the queue read latency
module stream_skid_buffer
    import frame_stream_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_tvalid,
    input  logic [WORD_W-1:0] in_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [WORD_W-1:0] out_tdata,
    output logic [1:0]        occupancy
);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign pop        = out_tvalid && out_tready;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push       = in_tvalid && ((count != 2'd2) || pop);
    assign out_tvalid = (count != 2'd0);
    assign out_tdata  = mem[rd_ptr];
    assign occupancy  = count;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Word storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_tdata;
    end

endmodule

// File: rtl/frame_stream_decoder.sv
// rtl/frame_stream_decoder.sv - pops framed pixel words, tracks row/frame position and emits coordinated pixels
module frame_stream_decoder
    import frame_stream_decoder_pkg::*;
#(
    parameter int FRAME_WIDTH        = 480,
    parameter int FRAME_HEIGHT       = 272,
    parameter bit EXPECT_ROW_MARKERS = 1'b1,
    parameter bit EXPECT_FRAME_END   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               queue_empty,
    input  logic [WORD_W-1:0]  queue_data,
    output logic               queue_rd_en,
    output logic               queue_rd_clk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_data,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_eol,
    output logic               out_eof,
    output logic               frame_done,
    input  logic               err_clear,
    output logic [ERR_W-1:0]   err_flags
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_HEIGHT - 1);
    localparam decoder_state_t ROW_ENTRY  = EXPECT_ROW_MARKERS ? ST_ROW_HDR : ST_PIXELS;

    decoder_state_t     state;
    decoder_state_t     next_state;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    logic               inflight;
    logic [1:0]         skid_occ;
    logic               head_valid;
    logic [WORD_W-1:0]  head_word;
    logic               consume;
    logic [2:0]         pending;

    logic               emit;
    logic               done_set;
    logic [ERR_W-1:0]   err_set;
    logic               out_free;

    logic               w_fs;
    logic               w_rs;
    logic               w_fe;
    logic               w_pix;
    logic               w_unk;
    logic               row_done;
    logic               last_row;
    logic               pix_go;

    assign queue_rd_clk = clk;

    // Words already owned by the skid or in flight, minus the one leaving this cycle.
    assign pending     = {1'b0, skid_occ} + {2'b00, inflight} - {2'b00, consume};
    assign queue_rd_en = reset_n && !queue_empty && (pending < 3'd2);

    // The queue presents data one cycle after the pop strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) inflight <= 1'b0;
        else          inflight <= queue_rd_en;
    end

    stream_skid_buffer u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_tvalid  (inflight),
        .in_tdata   (queue_data),
        .out_tvalid (head_valid),
        .out_tready (consume),
        .out_tdata  (head_word),
        .occupancy  (skid_occ)
    );

    assign out_free = !out_valid || out_ready;
    assign w_fs     = head_valid && (head_word == MARKER_FRAME_START);
    assign w_rs     = head_valid && (head_word == MARKER_ROW_START);
    assign w_fe     = head_valid && (head_word == MARKER_FRAME_END);
    assign w_pix    = head_valid && !is_marker(head_word);
    assign w_unk    = head_valid && is_marker(head_word) && !w_fs && !w_rs && !w_fe;
    assign row_done = (x == X_LAST);
    assign last_row = (y == Y_LAST);
    assign pix_go   = (state == ST_PIXELS) && w_pix && out_free;

    // State and position register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_SYNC;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= next_state;
            x     <= next_x;
            y     <= next_y;
        end
    end

    // Next state and position from the word at the skid head.
    always_comb begin
        next_state = state;
        next_x     = x;
        next_y     = y;
        if (w_fs) begin
            next_x     = '0;
            next_y     = '0;
            next_state = ROW_ENTRY;
        end else begin
            case (state)
                ST_SYNC: begin
                    next_state = ST_SYNC;
                end
                ST_ROW_HDR: begin
                    if (w_rs)      next_state = ST_PIXELS;
                    else if (w_fe) next_state = ST_SYNC;
                end
                ST_PIXELS: begin
                    if (pix_go) begin
                        if (row_done) begin
                            next_x = '0;
                            if (!last_row) begin
                                next_y     = y + 11'd1;
                                next_state = ROW_ENTRY;
                            end else begin
                                next_state = EXPECT_FRAME_END ? ST_FRAME_END : ST_SYNC;
                            end
                        end else begin
                            next_x = x + 11'd1;
                        end
                    end else if (w_rs) begin
                        // Short row: the marker doubles as the next row's header.
                        next_x = '0;
                        if (last_row) next_state = ST_SYNC;
                        else          next_y = y + 11'd1;
                    end else if (w_fe) begin
                        next_state = ST_SYNC;
                    end
                end
                ST_FRAME_END: begin
                    if (w_fe) next_state = ST_SYNC;
                end
                default: next_state = ST_SYNC;
            endcase
        end
    end

    // Consume, emit, error and frame-close decisions for the head word.
    always_comb begin
        consume  = 1'b0;
        emit     = 1'b0;
        done_set = 1'b0;
        err_set  = '0;
        if (head_valid) begin
            consume = 1'b1;
            if (w_fs) begin
                if (state != ST_SYNC) err_set[ERR_RESYNC] = 1'b1;
            end else if (state == ST_SYNC) begin
                consume = 1'b1;
            end else if (w_fe) begin
                if (state == ST_FRAME_END) done_set = 1'b1;
                else                       err_set[ERR_FRAME_END] = 1'b1;
            end else if (w_unk) begin
                err_set[ERR_UNKNOWN_MARKER] = 1'b1;
            end else begin
                case (state)
                    ST_ROW_HDR: begin
                        if (w_pix) err_set[ERR_ROW_LEN] = 1'b1;
                    end
                    ST_PIXELS: begin
                        if (w_pix) begin
                            // Only pixels wait for the output register.
                            consume = out_free;
                            emit    = out_free;
                            if (out_free && row_done && last_row && !EXPECT_FRAME_END)
                                done_set = 1'b1;
                        end else begin
                            err_set[ERR_ROW_LEN] = 1'b1;
                        end
                    end
                    ST_FRAME_END: begin
                        err_set[ERR_FRAME_END] = 1'b1;
                    end
                    default: consume = 1'b1;
                endcase
            end
        end
    end

    // Output register holds its contents while the downstream stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= head_word[PIX_W-1:0];
            out_x     <= x;
            out_y     <= y;
            out_eol   <= row_done;
            out_eof   <= row_done && last_row;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags and the frame-closed pulse; a new error wins over a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_flags  <= '0;
            frame_done <= 1'b0;
        end else begin
            err_flags  <= (err_clear ? '0 : err_flags) | err_set;
            frame_done <= done_set;
        end
    end

endmodule

// File: tb/tb_frame_stream_decoder.sv
// tb/tb_frame_stream_decoder.sv - scoreboard bench for the frame stream decoder
module tb_frame_stream_decoder;
    import frame_stream_decoder_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [15:0] data;
        logic [10:0] x;
        logic [10:0] y;
        logic        eol;
        logic        eof;
    } pix_t;

    int checks = 0;
    int fails  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    logic        a_empty = 1'b1, a_rd_en, a_rd_clk, a_valid, a_ready = 1'b0, a_eol, a_eof, a_done, a_clr = 1'b0;
    logic [16:0] a_qdata = '0;
    logic [15:0] a_data;
    logic [10:0] a_x, a_y;
    logic [3:0]  a_err;
    logic        b_empty = 1'b1, b_rd_en, b_rd_clk, b_valid, b_ready = 1'b0, b_eol, b_eof, b_done, b_clr = 1'b0;
    logic [16:0] b_qdata = '0;
    logic [15:0] b_data;
    logic [10:0] b_x, b_y;
    logic [3:0]  b_err;

    frame_stream_decoder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                           .EXPECT_ROW_MARKERS(1'b1), .EXPECT_FRAME_END(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .queue_empty(a_empty), .queue_data(a_qdata),
        .queue_rd_en(a_rd_en), .queue_rd_clk(a_rd_clk), .out_valid(a_valid), .out_ready(a_ready),
        .out_data(a_data), .out_x(a_x), .out_y(a_y), .out_eol(a_eol), .out_eof(a_eof),
        .frame_done(a_done), .err_clear(a_clr), .err_flags(a_err));

    frame_stream_decoder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                           .EXPECT_ROW_MARKERS(1'b0), .EXPECT_FRAME_END(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .queue_empty(b_empty), .queue_data(b_qdata),
        .queue_rd_en(b_rd_en), .queue_rd_clk(b_rd_clk), .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_data), .out_x(b_x), .out_y(b_y), .out_eol(b_eol), .out_eof(b_eof),
        .frame_done(b_done), .err_clear(b_clr), .err_flags(b_err));

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    pix_t        sb_a[$];
    pix_t        sb_b[$];
    logic        a_pop_bad = 1'b0;
    logic        b_pop_bad = 1'b0;

    // Queue model: the popped word appears on queue_data the cycle after the strobe.
    always @(posedge clk) begin
        if (a_rd_en) begin
            if (qa.size() == 0) a_pop_bad <= 1'b1;
            else                a_qdata <= qa.pop_front();
        end
        if (b_rd_en) begin
            if (qb.size() == 0) b_pop_bad <= 1'b1;
            else                b_qdata <= qb.pop_front();
        end
    end

    always @(negedge clk) begin
        a_empty = (qa.size() == 0);
        b_empty = (qb.size() == 0);
    end

    function automatic pix_t mk_pix(input logic [15:0] d, input int x, input int y);
        pix_t p;
        p.data = d;
        p.x    = 11'(x);
        p.y    = 11'(y);
        p.eol  = (x == W - 1);
        p.eof  = (x == W - 1) && (y == H - 1);
        return p;
    endfunction

    task automatic pix_a(input int x, input int y);
        logic [15:0] d;
        d = 16'($urandom);
        qa.push_back({1'b0, d});
        sb_a.push_back(mk_pix(d, x, y));
    endtask

    task automatic row_a(input int y, input int n);
        qa.push_back(MARKER_ROW_START);
        for (int x = 0; x < n; x++) pix_a(x, y);
    endtask

    task automatic frame_a;
        qa.push_back(MARKER_FRAME_START);
        for (int y = 0; y < H; y++) row_a(y, W);
        qa.push_back(MARKER_FRAME_END);
    endtask

    task automatic drain_a(input string name, input bit rand_ready, output int done_cnt);
        pix_t got, exp_p, held;
        bit   stalled;
        int   cyc, tail;
        stalled  = 1'b0;
        cyc      = 0;
        tail     = 0;
        done_cnt = 0;
        held     = '0;
        while ((sb_a.size() > 0 || tail < 10) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sb_a.size() == 0) tail++;
            if (a_done) done_cnt++;
            got = {a_data, a_x, a_y, a_eol, a_eof};
            if (stalled) begin
                checks++;
                if (!a_valid || got !== held) begin
                    fails++;
                    $display("FAIL %s stall_hold: got valid=%0b word=%h, required valid=1 word=%h", name, a_valid, got, held);
                end
            end
            a_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_valid && a_ready) begin
                checks++;
                if (sb_a.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra_pixel: got x=%0d y=%0d, required no pixel", name, a_x, a_y);
                end else begin
                    exp_p = sb_a.pop_front();
                    if (got !== exp_p) begin
                        fails++;
                        $display("FAIL %s pixel: got d=%h x=%0d y=%0d eol=%0b eof=%0b, required d=%h x=%0d y=%0d eol=%0b eof=%0b",
                                 name, got.data, got.x, got.y, got.eol, got.eof,
                                 exp_p.data, exp_p.x, exp_p.y, exp_p.eol, exp_p.eof);
                    end
                end
            end
            stalled = a_valid && !a_ready;
            held    = got;
        end
        a_ready = 1'b1;
        checks++;
        if (sb_a.size() != 0) begin
            fails++;
            $display("FAIL %s timeout: got %0d pixels outstanding, required 0", name, sb_a.size());
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_valid, a_rd_en, a_done, a_err, a_x, a_y, a_data, a_eol, a_eof} !== '0) begin
            fails++;
            $display("FAIL reset_a: got valid=%0b rd=%0b done=%0b err=%h x=%0d y=%0d, required all 0",
                     a_valid, a_rd_en, a_done, a_err, a_x, a_y);
        end
        checks++;
        if ({b_valid, b_rd_en, b_done, b_err, b_x, b_y, b_data, b_eol, b_eof} !== '0) begin
            fails++;
            $display("FAIL reset_b: got valid=%0b rd=%0b done=%0b err=%h x=%0d y=%0d, required all 0",
                     b_valid, b_rd_en, b_done, b_err, b_x, b_y);
        end
        checks++;
        if (a_rd_clk !== clk) begin
            fails++;
            $display("FAIL rd_clk: got %0b, required %0b", a_rd_clk, clk);
        end
        reset_n = 1'b1;
        a_ready = 1'b1;
    endtask

    task automatic test_full_frame;
        int d;
        frame_a();
        drain_a("full_frame", 1'b0, d);
        checks++;
        if (d != 1) begin fails++; $display("FAIL full_frame done: got %0d pulses, required 1", d); end
        checks++;
        if (a_err !== 4'b0000) begin fails++; $display("FAIL full_frame err: got %b, required 0000", a_err); end
    endtask

    task automatic test_backpressure;
        int d;
        frame_a();
        drain_a("backpressure", 1'b1, d);
        checks++;
        if (d != 1) begin fails++; $display("FAIL backpressure done: got %0d pulses, required 1", d); end
        checks++;
        if (a_err !== 4'b0000) begin fails++; $display("FAIL backpressure err: got %b, required 0000", a_err); end
    endtask

    task automatic test_short_row;
        int d;
        qa.push_back(MARKER_FRAME_START);
        row_a(0, W);
        row_a(1, 3);
        row_a(2, W);
        qa.push_back(MARKER_FRAME_END);
        drain_a("short_row", 1'b0, d);
        checks++;
        if (a_err !== 4'b0010) begin fails++; $display("FAIL short_row err: got %b, required 0010", a_err); end
        checks++;
        if (d != 1) begin fails++; $display("FAIL short_row done: got %0d pulses, required 1", d); end
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
    endtask

    task automatic test_resync;
        int d;
        qa.push_back(MARKER_FRAME_START);
        row_a(0, W);
        row_a(1, 2);
        frame_a();
        drain_a("resync", 1'b0, d);
        checks++;
        if (a_err !== 4'b0001) begin fails++; $display("FAIL resync err: got %b, required 0001", a_err); end
        checks++;
        if (d != 1) begin fails++; $display("FAIL resync done: got %0d pulses, required 1", d); end
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
    endtask

    task automatic test_unknown_marker;
        int d;
        qa.push_back(MARKER_FRAME_START);
        row_a(0, W);
        qa.push_back(MARKER_ROW_START);
        pix_a(0, 1);
        pix_a(1, 1);
        qa.push_back(17'h10005);
        pix_a(2, 1);
        pix_a(3, 1);
        row_a(2, W);
        qa.push_back(MARKER_FRAME_END);
        drain_a("unknown_marker", 1'b0, d);
        checks++;
        if (a_err !== 4'b0100) begin fails++; $display("FAIL unknown_marker err: got %b, required 0100", a_err); end
        checks++;
        if (d != 1) begin fails++; $display("FAIL unknown_marker done: got %0d pulses, required 1", d); end
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
        checks++;
        if (a_err !== 4'b0000) begin fails++; $display("FAIL err_clear: got %b, required 0000", a_err); end
    endtask

    task automatic test_back_to_back;
        int d;
        frame_a();
        frame_a();
        drain_a("back_to_back", 1'b0, d);
        checks++;
        if (d != 2) begin fails++; $display("FAIL back_to_back done: got %0d pulses, required 2", d); end
        checks++;
        if (a_pop_bad !== 1'b0) begin fails++; $display("FAIL pop_empty_a: got %0b, required 0", a_pop_bad); end
    endtask

    task automatic test_reset_mid_frame;
        int   d, cyc, tail;
        pix_t got, e;
        logic [15:0] v;
        b_ready = 1'b1;
        qb.push_back(MARKER_FRAME_START);
        for (int i = 0; i < 6; i++) qb.push_back({1'b0, 16'($urandom)});
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_valid, b_rd_en, b_done, b_err, b_x, b_y, b_data, b_eol, b_eof} !== '0) begin
            fails++;
            $display("FAIL mid_reset_b: got valid=%0b rd=%0b done=%0b err=%h x=%0d y=%0d, required all 0",
                     b_valid, b_rd_en, b_done, b_err, b_x, b_y);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) qb.push_back({1'b0, 16'($urandom)});
        qb.push_back(MARKER_FRAME_START);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                v = 16'($urandom);
                qb.push_back({1'b0, v});
                sb_b.push_back(mk_pix(v, x, y));
            end
        end
        d = 0; cyc = 0; tail = 0;
        while ((sb_b.size() > 0 || tail < 10) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sb_b.size() == 0) tail++;
            if (b_done) d++;
            if (b_valid) begin
                got = {b_data, b_x, b_y, b_eol, b_eof};
                checks++;
                if (sb_b.size() == 0) begin
                    fails++;
                    $display("FAIL no_markers extra_pixel: got x=%0d y=%0d, required no pixel", b_x, b_y);
                end else begin
                    e = sb_b.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL no_markers pixel: got d=%h x=%0d y=%0d eol=%0b eof=%0b, required d=%h x=%0d y=%0d eol=%0b eof=%0b",
                                 got.data, got.x, got.y, got.eol, got.eof, e.data, e.x, e.y, e.eol, e.eof);
                    end
                end
            end
        end
        checks++;
        if (sb_b.size() != 0) begin fails++; $display("FAIL no_markers timeout: got %0d outstanding, required 0", sb_b.size()); end
        checks++;
        if (d != 1) begin fails++; $display("FAIL no_markers done: got %0d pulses, required 1", d); end
        checks++;
        if (b_err !== 4'b0000) begin fails++; $display("FAIL no_markers err: got %b, required 0000", b_err); end
        checks++;
        if (b_pop_bad !== 1'b0) begin fails++; $display("FAIL pop_empty_b: got %0b, required 0", b_pop_bad); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_row();
        test_resync();
        test_unknown_marker();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
